// File: rtl/five_dmem_dma.sv
// five_dmem_dma: block copy / block fill initiator for a single-port data memory.
// The memory reads asynchronously and writes on posedge when mem_wr is high.
// Copy moves one word per RD/WR pair in ascending address order.
// Fill writes one word per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; memory port driven to zero
// RD    | copy: present src_ptr, capture mem_rdata into the buffer
// WR    | copy: write the buffer to dst_ptr
// FILL  | fill: write the fill value to dst_ptr
// DONE  | one-cycle completion pulse, then back to IDLE
module five_dmem_dma #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] fill_data,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] words_done
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] src_ptr_q, src_ptr_d;
   logic [AW-1:0] dst_ptr_q, dst_ptr_d;
   logic [AW-1:0] remaining_q, remaining_d;
   logic [AW-1:0] words_done_q, words_done_d;
   logic [DW-1:0] data_buf_q, data_buf_d;
   logic [DW-1:0] fill_q, fill_d;

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         src_ptr_q    <= '0;
         dst_ptr_q    <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
         data_buf_q   <= '0;
         fill_q       <= '0;
      end else begin
         state_q      <= state_d;
         src_ptr_q    <= src_ptr_d;
         dst_ptr_q    <= dst_ptr_d;
         remaining_q  <= remaining_d;
         words_done_q <= words_done_d;
         data_buf_q   <= data_buf_d;
         fill_q       <= fill_d;
      end
   end

   // Next-state logic and memory-port decode from registered state.
   // The mode bit is folded into the first state chosen at acceptance.
   always_comb begin
      state_d      = state_q;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      remaining_d  = remaining_q;
      words_done_d = words_done_q;
      data_buf_d   = data_buf_q;
      fill_d       = fill_q;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wr       = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_ptr_d    = src_addr;
               dst_ptr_d    = dst_addr;
               remaining_d  = len;
               fill_d       = fill_data;
               words_done_d = '0;
               if (len == '0)
                  state_d = S_DONE;
               else if (mode)
                  state_d = S_FILL;
               else
                  state_d = S_RD;
            end
         end
         S_RD: begin
            busy       = 1'b1;
            mem_addr   = src_ptr_q;
            data_buf_d = mem_rdata;
            src_ptr_d  = src_ptr_q + AW'(1);
            state_d    = S_WR;
         end
         S_WR: begin
            busy         = 1'b1;
            mem_addr     = dst_ptr_q;
            mem_wdata    = data_buf_q;
            mem_wr       = 1'b1;
            dst_ptr_d    = dst_ptr_q + AW'(1);
            remaining_d  = remaining_q - AW'(1);
            words_done_d = words_done_q + AW'(1);
            state_d      = (remaining_q == AW'(1)) ? S_DONE : S_RD;
         end
         S_FILL: begin
            busy         = 1'b1;
            mem_addr     = dst_ptr_q;
            mem_wdata    = fill_q;
            mem_wr       = 1'b1;
            dst_ptr_d    = dst_ptr_q + AW'(1);
            remaining_d  = remaining_q - AW'(1);
            words_done_d = words_done_q + AW'(1);
            if (remaining_q == AW'(1))
               state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign words_done = words_done_q;

endmodule

// File: tb/tb_five_dmem_dma.sv
// Testbench for five_dmem_dma: behavioural 4K x 16 memory plus per-scenario tasks.
// Expected writes are queued when a command is issued.
// Observed writes are collected as the DUT performs them, then the two are compared.
module tb_five_dmem_dma;

   localparam int AW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW-1:0] len = '0;
   logic [DW-1:0] fill_data = '0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          done;
   logic [AW-1:0] words_done;

   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            c;
   } wr_t;
   wr_t exp_q[$];
   wr_t obs_q[$];

   five_dmem_dma #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .words_done(words_done)
   );

   always #5 clk = ~clk;

   // Single-port memory: DUT writes take priority over bench preloads.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
      wr_t e;
      e.a = a; e.d = d; e.c = c;
      exp_q.push_back(e);
   endtask

   // Issue one command and observe it; cycle 1 is the cycle after the sampling edge.
   // A second start pulse can be injected at cycle restart_cyc (0 = none).
   task automatic run_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] f, input int restart_cyc,
                         input int budget, output int done_cyc, output int busy_cnt,
                         output int done_cnt);
      wr_t o;
      done_cyc = 0; busy_cnt = 0; done_cnt = 0;
      obs_q.delete();
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (mem_wr) begin
            o.a = mem_addr; o.d = mem_wdata; o.c = c;
            obs_q.push_back(o);
         end
         if (c == restart_cyc) begin
            start = 1'b1; mode = 1'b1; dst_addr = 12'hABC; len = 12'd2; fill_data = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         if (done_cyc != 0 && c >= done_cyc + 2) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || words_done !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b wr=%b addr=%h wdata=%h wd=%0d want all zero",
                  busy, done, mem_wr, mem_addr, mem_wdata, words_done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      int dc, bc, nc;
      wr_t e, o;
      for (int i = 0; i < 3; i++) push_exp(AW'(12'h100 + i), 16'hA5A5, i + 1);
      run_op(1'b1, 12'h000, 12'h100, 12'd3, 16'hA5A5, 0, 40, dc, bc, nc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL fill_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
            errors++;
            $display("FAIL fill_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                     o.a, o.d, o.c, e.a, e.d, e.c);
         end
      end
      exp_q.delete();
      checks++;
      if (dc != 4 || nc != 1 || bc != 3) begin
         errors++;
         $display("FAIL fill_timing: got done_cyc=%0d pulses=%0d busy=%0d want 4 1 3", dc, nc, bc);
      end
      checks++;
      if (words_done !== 12'd3) begin
         errors++;
         $display("FAIL fill_words_done: got %0d want 3", words_done);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[12'h100 + i] !== 16'hA5A5) begin
            errors++;
            $display("FAIL fill_mem: addr %h got %h want a5a5", 12'h100 + i, mem[12'h100 + i]);
         end
      end
   endtask

   task automatic test_copy();
      int dc, bc, nc;
      wr_t e, o;
      logic [DW-1:0] src_vals [3];
      src_vals[0] = 16'h0002; src_vals[1] = 16'h4DF8; src_vals[2] = 16'h0003;
      for (int i = 0; i < 3; i++) preload(AW'(i), src_vals[i]);
      for (int i = 0; i < 3; i++) push_exp(AW'(12'h010 + i), src_vals[i], 2 * i + 2);
      run_op(1'b0, 12'h000, 12'h010, 12'd3, 16'h0000, 0, 40, dc, bc, nc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL copy_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
            errors++;
            $display("FAIL copy_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                     o.a, o.d, o.c, e.a, e.d, e.c);
         end
      end
      exp_q.delete();
      checks++;
      if (dc != 7 || nc != 1 || bc != 6 || words_done !== 12'd3) begin
         errors++;
         $display("FAIL copy_timing: got done_cyc=%0d pulses=%0d busy=%0d wd=%0d want 7 1 6 3",
                  dc, nc, bc, words_done);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[i] !== src_vals[i] || mem[12'h010 + i] !== src_vals[i]) begin
            errors++;
            $display("FAIL copy_mem: idx %0d got src=%h dst=%h want %h", i, mem[i],
                     mem[12'h010 + i], src_vals[i]);
         end
      end
   endtask

   task automatic test_wrap();
      int dc, bc, nc;
      wr_t e, o;
      preload(12'h001, 16'hBEEF);
      push_exp(12'hFFE, 16'h1234, 1);
      push_exp(12'hFFF, 16'h1234, 2);
      push_exp(12'h000, 16'h1234, 3);
      run_op(1'b1, 12'h000, 12'hFFE, 12'd3, 16'h1234, 0, 40, dc, bc, nc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wrap_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
            errors++;
            $display("FAIL wrap_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                     o.a, o.d, o.c, e.a, e.d, e.c);
         end
      end
      exp_q.delete();
      checks++;
      if (mem[12'h001] !== 16'hBEEF || mem[12'h000] !== 16'h1234 || dc != 4) begin
         errors++;
         $display("FAIL wrap_mem: got m001=%h m000=%h done_cyc=%0d want beef 1234 4",
                  mem[12'h001], mem[12'h000], dc);
      end
   endtask

   task automatic test_zero_len();
      int dc, bc, nc;
      run_op(1'b1, 12'h000, 12'h500, 12'd0, 16'h9999, 0, 20, dc, bc, nc);
      checks++;
      if (dc != 1 || bc != 0 || nc != 1 || obs_q.size() != 0 || words_done !== '0) begin
         errors++;
         $display("FAIL zero_len: got done_cyc=%0d busy=%0d pulses=%0d writes=%0d wd=%0d want 1 0 1 0 0",
                  dc, bc, nc, obs_q.size(), words_done);
      end
   endtask

   task automatic test_back_to_back();
      int dc, bc, nc;
      wr_t e, o;
      for (int i = 0; i < 8; i++) preload(AW'(12'h300 + i), DW'(16'h1000 + 16'h0111 * i));
      for (int i = 0; i < 8; i++)
         push_exp(AW'(12'h400 + i), DW'(16'h1000 + 16'h0111 * i), 2 * i + 2);
      run_op(1'b0, 12'h300, 12'h400, 12'd8, 16'h0000, 3, 60, dc, bc, nc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL busy_start_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
            errors++;
            $display("FAIL busy_start_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                     o.a, o.d, o.c, e.a, e.d, e.c);
         end
      end
      exp_q.delete();
      checks++;
      if (dc != 17 || nc != 1 || bc != 16 || words_done !== 12'd8) begin
         errors++;
         $display("FAIL busy_start_timing: got done_cyc=%0d pulses=%0d busy=%0d wd=%0d want 17 1 16 8",
                  dc, nc, bc, words_done);
      end
   endtask

   task automatic test_reset_mid_op();
      int dc, bc, nc;
      preload(12'h202, 16'hDEAD);
      @(negedge clk);
      start = 1'b1; mode = 1'b1; dst_addr = 12'h200; len = 12'd5; fill_data = 16'h5555;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== 12'h202) begin
         errors++;
         $display("FAIL rst_mid_pre: got wr=%b addr=%h want 1 202", mem_wr, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
          words_done !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got busy=%b wr=%b addr=%h wdata=%h wd=%0d done=%b want zeros",
                  busy, mem_wr, mem_addr, mem_wdata, words_done, done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (mem[12'h200] !== 16'h5555 || mem[12'h201] !== 16'h5555 || mem[12'h202] !== 16'hDEAD) begin
         errors++;
         $display("FAIL rst_mid_mem: got %h %h %h want 5555 5555 dead",
                  mem[12'h200], mem[12'h201], mem[12'h202]);
      end
      run_op(1'b1, 12'h000, 12'h202, 12'd1, 16'h7777, 0, 20, dc, bc, nc);
      checks++;
      if (dc != 2 || obs_q.size() != 1 || mem[12'h202] !== 16'h7777 || words_done !== 12'd1) begin
         errors++;
         $display("FAIL rst_mid_restart: got done_cyc=%0d writes=%0d mem=%h wd=%0d want 2 1 7777 1",
                  dc, obs_q.size(), mem[12'h202], words_done);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_copy();
      test_wrap();
      test_zero_len();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
